// File: rtl/btb_update_ctrl.sv
// Write-side controller for the dual-pipe BTB: merges branch resolutions from
// both EX stages, updates the 2-bit predictor and drains an in-order FIFO into the BTB write port.
module btb_update_ctrl #(
  parameter int         QDEPTH   = 4,
  parameter logic [1:0] ALLOC_ST = 2'b10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Res0Valid,
  input  logic [31:0] Res0PC,
  input  logic [31:0] Res0Target,
  input  logic        Res0Taken,
  input  logic        Res0Hit,
  input  logic [1:0]  Res0State,
  output logic        Res0Ready,
  input  logic        Res1Valid,
  input  logic [31:0] Res1PC,
  input  logic [31:0] Res1Target,
  input  logic        Res1Taken,
  input  logic        Res1Hit,
  input  logic [1:0]  Res1State,
  output logic        Res1Ready,
  output logic        BtbWe,
  output logic [31:0] BtbPC,
  output logic [31:0] BtbTarget,
  output logic [1:0]  BtbState,
  output logic [2:0]  QCount
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(QDEPTH);
  localparam logic [PW:0] ONE_C   = (PW+1)'(1);
  localparam logic [PW:0] TWO_C   = (PW+1)'(2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  state;
  } entry_t;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  entry_t       fifo_mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   free_slots;
  state_t        fsm_state;
  logic          enq0;
  logic          enq1;
  logic          deq;

  function automatic logic [1:0] next_pred(input logic hit, input logic taken,
                                           input logic [1:0] cur);
    logic [1:0] res;
    res = ALLOC_ST;
    if (hit && taken)
      res = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
    else if (hit && !taken)
      res = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
    return res;
  endfunction

  // Readiness ignores the filter and any same-cycle pop, so a full queue never overflows.
  always_comb begin
    free_slots = DEPTH_C - count;
    Res0Ready  = !Reset && (free_slots >= ONE_C);
    Res1Ready  = !Reset && (Res0Valid ? (free_slots >= TWO_C) : (free_slots >= ONE_C));
    enq0       = Res0Valid && Res0Ready && (Res0Hit || Res0Taken);
    enq1       = Res1Valid && Res1Ready && (Res1Hit || Res1Taken);
    deq        = (count != '0);
  end

  assign QCount = 3'(count);

  // Pipe 0 is older, so it always takes the lower slot on a dual enqueue.
  always_ff @(posedge Clk) begin
    if (enq0)
      fifo_mem[wr_ptr] <= '{pc: Res0PC, target: Res0Target,
                            state: next_pred(Res0Hit, Res0Taken, Res0State)};
    if (enq1)
      fifo_mem[wr_ptr + PW'(enq0)] <= '{pc: Res1PC, target: Res1Target,
                                       state: next_pred(Res1Hit, Res1Taken, Res1State)};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fsm_state <= IDLE;
      BtbWe     <= 1'b0;
      BtbPC     <= '0;
      BtbTarget <= '0;
      BtbState  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(enq0) + PW'(enq1);
      rd_ptr <= rd_ptr + PW'(deq);
      count  <= count + (PW+1)'(enq0) + (PW+1)'(enq1) - (PW+1)'(deq);
      case (fsm_state)
        IDLE: begin
          if (deq) begin
            BtbWe     <= 1'b1;
            BtbPC     <= fifo_mem[rd_ptr].pc;
            BtbTarget <= fifo_mem[rd_ptr].target;
            BtbState  <= fifo_mem[rd_ptr].state;
            fsm_state <= WRITE;
          end else begin
            BtbWe <= 1'b0;
          end
        end
        WRITE: begin
          if (deq) begin
            BtbWe     <= 1'b1;
            BtbPC     <= fifo_mem[rd_ptr].pc;
            BtbTarget <= fifo_mem[rd_ptr].target;
            BtbState  <= fifo_mem[rd_ptr].state;
          end else begin
            BtbWe     <= 1'b0;
            fsm_state <= IDLE;
          end
        end
        default: begin
          BtbWe     <= 1'b0;
          fsm_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed scenarios plus random traffic
// checked each cycle against a queue-based model of the update FIFO.
module tb_btb_update_ctrl;

  localparam int QDEPTH = 4;

  logic        Clk;
  logic        Reset;
  logic        Res0Valid, Res0Taken, Res0Hit, Res0Ready;
  logic [31:0] Res0PC, Res0Target;
  logic [1:0]  Res0State;
  logic        Res1Valid, Res1Taken, Res1Hit, Res1Ready;
  logic [31:0] Res1PC, Res1Target;
  logic [1:0]  Res1State;
  logic        BtbWe;
  logic [31:0] BtbPC, BtbTarget;
  logic [1:0]  BtbState;
  logic [2:0]  QCount;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  st;
  } ent_t;

  ent_t        modelQ[$];
  logic        expWe;
  logic [31:0] expPC, expTarget;
  logic [1:0]  expState;
  int          checkCount = 0;
  int          passCount  = 0;

  btb_update_ctrl #(.QDEPTH(QDEPTH), .ALLOC_ST(2'b10)) dut (
    .Clk(Clk), .Reset(Reset),
    .Res0Valid(Res0Valid), .Res0PC(Res0PC), .Res0Target(Res0Target),
    .Res0Taken(Res0Taken), .Res0Hit(Res0Hit), .Res0State(Res0State), .Res0Ready(Res0Ready),
    .Res1Valid(Res1Valid), .Res1PC(Res1PC), .Res1Target(Res1Target),
    .Res1Taken(Res1Taken), .Res1Hit(Res1Hit), .Res1State(Res1State), .Res1Ready(Res1Ready),
    .BtbWe(BtbWe), .BtbPC(BtbPC), .BtbTarget(BtbTarget), .BtbState(BtbState), .QCount(QCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  // Predictor update written directly from the saturating-counter rules.
  function automatic logic [1:0] predict(input bit hit, input bit taken, input logic [1:0] st);
    int s;
    if (!hit) return 2'b10;
    s = int'(st) + (taken ? 1 : -1);
    if (s > 3) s = 3;
    if (s < 0) s = 0;
    return 2'(s);
  endfunction

  // One clock: drive at the falling edge, check readiness, advance the model, check outputs.
  task automatic applyStimulus(input bit rst,
                               input bit v0, input logic [31:0] pc0, input logic [31:0] tg0,
                               input bit tk0, input bit h0, input logic [1:0] st0,
                               input bit v1, input logic [31:0] pc1, input logic [31:0] tg1,
                               input bit tk1, input bit h1, input logic [1:0] st1);
    int fr;
    bit r0, r1;
    ent_t e;
    Reset = rst;
    Res0Valid = v0; Res0PC = pc0; Res0Target = tg0; Res0Taken = tk0; Res0Hit = h0; Res0State = st0;
    Res1Valid = v1; Res1PC = pc1; Res1Target = tg1; Res1Taken = tk1; Res1Hit = h1; Res1State = st1;
    #1;
    fr = QDEPTH - modelQ.size();
    r0 = !rst && (fr >= 1);
    r1 = !rst && (v0 ? (fr >= 2) : (fr >= 1));
    checkOutput("Res0Ready", {31'b0, Res0Ready}, {31'b0, r0});
    checkOutput("Res1Ready", {31'b0, Res1Ready}, {31'b0, r1});
    if (rst) begin
      modelQ.delete();
      expWe = 1'b0; expPC = '0; expTarget = '0; expState = '0;
    end else begin
      if (modelQ.size() > 0) begin
        e = modelQ.pop_front();
        expWe = 1'b1; expPC = e.pc; expTarget = e.tgt; expState = e.st;
      end else begin
        expWe = 1'b0;
      end
      if (v0 && r0 && (h0 || tk0)) modelQ.push_back('{pc0, tg0, predict(h0, tk0, st0)});
      if (v1 && r1 && (h1 || tk1)) modelQ.push_back('{pc1, tg1, predict(h1, tk1, st1)});
    end
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("BtbWe",     {31'b0, BtbWe}, {31'b0, expWe});
    checkOutput("BtbPC",     BtbPC, expPC);
    checkOutput("BtbTarget", BtbTarget, expTarget);
    checkOutput("BtbState",  {30'b0, BtbState}, {30'b0, expState});
    checkOutput("QCount",    {29'b0, QCount}, 32'(modelQ.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resetCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Res0Valid = 0; Res0PC = 0; Res0Target = 0; Res0Taken = 0; Res0Hit = 0; Res0State = 0;
    Res1Valid = 0; Res1PC = 0; Res1Target = 0; Res1Taken = 0; Res1Hit = 0; Res1State = 0;
    @(negedge Clk);
    resetCycle();
    resetCycle();

    // Basic taken hit: handshake, then the write appears one cycle later.
    applyStimulus(0, 1, 32'h40, 32'h80, 1, 1, 2'd1, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_we_before", {31'b0, BtbWe}, 32'd0);
    idle(1);
    checkOutput("t1_we", {31'b0, BtbWe}, 32'd1);
    checkOutput("t1_pc", BtbPC, 32'h40);
    checkOutput("t1_state", {30'b0, BtbState}, 32'd2);
    idle(2);

    // Saturation at both ends.
    applyStimulus(0, 1, 32'h50, 32'h90, 1, 1, 2'd3, 0, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("t2_sat_hi", {30'b0, BtbState}, 32'd3);
    applyStimulus(0, 1, 32'h54, 32'h94, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("t2_sat_lo", {30'b0, BtbState}, 32'd0);
    idle(2);

    // Miss filter and miss allocation.
    applyStimulus(0, 1, 32'h60, 32'ha0, 0, 0, 2'd3, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_filt_q", {29'b0, QCount}, 32'd0);
    idle(1);
    checkOutput("t3_filt_we", {31'b0, BtbWe}, 32'd0);
    applyStimulus(0, 1, 32'h64, 32'ha4, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("t3_alloc", {30'b0, BtbState}, 32'd2);
    idle(2);

    // Dual issue: pipe 0 drains first.
    applyStimulus(0, 1, 32'h100, 32'h200, 1, 1, 2'd1, 1, 32'h104, 32'h204, 1, 1, 2'd2);
    checkOutput("t4_q2", {29'b0, QCount}, 32'd2);
    idle(1);
    checkOutput("t4_pc0", BtbPC, 32'h100);
    idle(1);
    checkOutput("t4_pc1", BtbPC, 32'h104);
    idle(2);

    // Fill with two valid per cycle, across pointer wrap.
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 32'h300 + 32'(i*8), 32'h400 + 32'(i), 1, 1, 2'(i),
                    1, 32'h304 + 32'(i*8), 32'h500 + 32'(i), 0, 1, 2'(i+1));
    idle(6);

    // Reset while writing with three entries queued.
    applyStimulus(0, 1, 32'h700, 32'h800, 1, 1, 2'd1, 1, 32'h704, 32'h804, 1, 1, 2'd1);
    applyStimulus(0, 1, 32'h708, 32'h808, 1, 1, 2'd1, 1, 32'h70c, 32'h80c, 1, 1, 2'd1);
    checkOutput("t6_q3", {29'b0, QCount}, 32'd3);
    checkOutput("t6_we1", {31'b0, BtbWe}, 32'd1);
    resetCycle();
    checkOutput("t6_we0", {31'b0, BtbWe}, 32'd0);
    checkOutput("t6_q0", {29'b0, QCount}, 32'd0);
    idle(3);
    checkOutput("t6_nowrite", {31'b0, BtbWe}, 32'd0);

    // Random traffic with occasional resets and bursty valids.
    for (int i = 0; i < 400; i++) begin
      int vp;
      vp = (i % 64 < 32) ? 85 : 30;
      applyStimulus(($urandom_range(99) < 2),
                    ($urandom_range(99) < vp), $urandom & 32'hfffffffc, $urandom,
                    1'($urandom), 1'($urandom), 2'($urandom),
                    ($urandom_range(99) < vp), $urandom & 32'hfffffffc, $urandom,
                    1'($urandom), 1'($urandom), 2'($urandom));
    end
    idle(6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
